// File: rtl/uart_rx_fifo_read_ctrl.sv
// Read-side controller for the UART->processor async FIFO: advances the read
// pointer, issues one-cycle RAM reads and hands bytes out over valid/ready.
module uart_rx_fifo_read_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  processor_clk,
    input  logic                  reset,
    input  logic                  comp_empty,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  flush,
    input  logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] r_add,
    output logic                  mem_rd_en,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic [CNT_WIDTH-1:0]  pop_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   r_add_next;
    logic                    mem_rd_en_next;
    logic [DATA_WIDTH-1:0]   rx_data_next;
    logic                    rx_valid_next;
    logic [CNT_WIDTH-1:0]    pop_count_next;

    // State and all outputs are registered; the comb block below only computes next values.
    always_ff @(posedge processor_clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            r_add     <= '0;
            mem_rd_en <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            pop_count <= '0;
        end else begin
            state     <= state_next;
            r_add     <= r_add_next;
            mem_rd_en <= mem_rd_en_next;
            rx_data   <= rx_data_next;
            rx_valid  <= rx_valid_next;
            pop_count <= pop_count_next;
        end
    end

    // Next-state and next-output decode; flush always takes priority.
    always_comb begin
        state_next     = state;
        r_add_next     = r_add;
        mem_rd_en_next = 1'b0;
        rx_data_next   = rx_data;
        rx_valid_next  = rx_valid;
        pop_count_next = pop_count;

        case (state)
            S_IDLE: begin
                if (flush) begin
                    state_next = S_DRAIN;
                end else if (!comp_empty) begin
                    state_next     = S_FETCH;
                    mem_rd_en_next = 1'b1;
                end
            end
            S_FETCH: begin
                // The byte is consumed from the FIFO even if a flush arrives now.
                r_add_next = r_add + ADDR_WIDTH'(1);
                state_next = flush ? S_DRAIN : S_CAPTURE;
            end
            S_CAPTURE: begin
                if (flush) begin
                    state_next = S_DRAIN;
                end else begin
                    rx_data_next  = mem_rd_data;
                    rx_valid_next = 1'b1;
                    state_next    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    rx_valid_next = 1'b0;
                    state_next    = S_DRAIN;
                end else if (rx_ready) begin
                    rx_valid_next = 1'b0;
                    if (pop_count != '1) begin
                        pop_count_next = pop_count + CNT_WIDTH'(1);
                    end
                    state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                // Stay while flush is held so late writes are discarded too.
                if (!comp_empty) begin
                    r_add_next = r_add + ADDR_WIDTH'(1);
                end else if (!flush) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
